// File: rtl/rda_subtractor32.sv
// Pipelined add/subtract unit using KPG-encoded recursive-doubling carry resolution.
// Three stages: operand capture, KPG + early prefix levels, late prefix levels + sum/flags.
module rda_subtractor32 #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LVL_S2 = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned IW     = (LEVELS > 0) ? LEVELS : 1;

    localparam logic [1:0] KPG_K = 2'b00;
    localparam logic [1:0] KPG_P = 2'b10;
    localparam logic [1:0] KPG_G = 2'b11;

    typedef logic [WIDTH-1:0][1:0] codes_t;

    function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
        return (hi == KPG_P) ? lo : hi;
    endfunction

    // Applies prefix levels [first, last) of the recursive-doubling network.
    function automatic codes_t prefix_range(input codes_t x, input int unsigned first,
                                            input int unsigned last);
        codes_t cur;
        codes_t nxt;
        cur = x;
        for (int unsigned j = 0; j < LEVELS; j++) begin
            if (j >= first && j < last) begin
                nxt = cur;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (i >= (32'd1 << j)) begin
                        nxt[IW'(i)] = kpg_combine(cur[IW'(i)], cur[IW'(i - (32'd1 << j))]);
                    end
                end
                cur = nxt;
            end
        end
        return cur;
    endfunction

    logic             advance;
    logic             s1_v;
    logic             s1_sub;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_bp;
    logic             s2_v;
    logic             s2_sub;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_bp;
    codes_t           s2_codes;

    codes_t           s1_kpg;
    codes_t           s1_pfx;
    codes_t           s2_pfx;
    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] sum_vec;
    logic             carry_msb;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = ~reset | advance;

    // Stage 2: slot 0 carries the carry-in, slot i holds the KPG of bit i-1.
    always_comb begin
        s1_kpg    = '0;
        s1_kpg[0] = s1_sub ? KPG_G : KPG_K;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            s1_kpg[IW'(i)] = {s1_a[IW'(i - 1)] | s1_bp[IW'(i - 1)],
                              s1_a[IW'(i - 1)] & s1_bp[IW'(i - 1)]};
        end
        s1_pfx = prefix_range(s1_kpg, 32'd0, LVL_S2);
    end

    // Stage 3: finish the prefix tree; slot i now resolves to the carry into bit i.
    always_comb begin
        s2_pfx    = prefix_range(s2_codes, LVL_S2, LEVELS);
        carry_vec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry_vec[IW'(i)] = &s2_pfx[IW'(i)];
        end
        sum_vec   = s2_a ^ s2_bp ^ carry_vec;
        carry_msb = (s2_a[WIDTH-1] & s2_bp[WIDTH-1]) |
                    ((s2_a[WIDTH-1] ^ s2_bp[WIDTH-1]) & carry_vec[WIDTH-1]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_v      <= 1'b0;
            s1_sub    <= 1'b0;
            s1_a      <= '0;
            s1_bp     <= '0;
            s2_v      <= 1'b0;
            s2_sub    <= 1'b0;
            s2_a      <= '0;
            s2_bp     <= '0;
            s2_codes  <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            s1_v      <= in_valid;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            if (in_valid) begin
                s1_a   <= a;
                s1_bp  <= sub ? ~b : b;
                s1_sub <= sub;
            end
            if (s1_v) begin
                s2_a     <= s1_a;
                s2_bp    <= s1_bp;
                s2_sub   <= s1_sub;
                s2_codes <= s1_pfx;
            end
            if (s2_v) begin
                result    <= sum_vec;
                carry_out <= carry_msb;
                borrow    <= s2_sub & ~carry_msb;
                overflow  <= carry_msb ^ carry_vec[WIDTH-1];
                zero      <= (sum_vec == '0);
            end
        end
    end

endmodule

// File: tb/tb_rda_subtractor32.sv
// Self-checking bench for rda_subtractor32: directed corner cases, stall streaming,
// mid-stream reset and a long random run against an arithmetic reference.
module tb_rda_subtractor32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out;
    logic        borrow;
    logic        overflow;
    logic        zero;

    int          tests = 0;
    int          fails = 0;
    int          n_acc = 0;
    int          n_con = 0;
    logic [35:0] sb[$];

    always #5 clock = ~clock;

    rda_subtractor32 dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry_out(carry_out),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    // Reference: {result, carry_out, borrow, overflow, zero}
    function automatic logic [35:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] t;
        logic [31:0] r;
        logic        c, bo, ov;
        if (s) begin
            r  = x - y;
            c  = (x >= y);
            bo = ~c;
            ov = (x[31] != y[31]) && (r[31] != x[31]);
        end else begin
            t  = {1'b0, x} + {1'b0, y};
            r  = t[31:0];
            c  = t[32];
            bo = 1'b0;
            ov = (x[31] == y[31]) && (r[31] != x[31]);
        end
        return {r, c, bo, ov, (r == 32'd0)};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive at negedge, then score handshake/consume/accept before the posedge.
    task automatic step(input logic rst, input logic iv, input logic s, input logic [31:0] aa,
                        input logic [31:0] bb, input logic ordy);
        logic [35:0] exp_v;
        logic [35:0] got_v;
        @(negedge clock);
        reset     = rst;
        in_valid  = iv;
        sub       = s;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        tests++;
        if (in_ready !== (~rst | ~out_valid | out_ready)) begin
            fails++;
            $display("FAIL in_ready: got %b want %b (reset=%b out_valid=%b out_ready=%b)",
                     in_ready, ~rst | ~out_valid | out_ready, rst, out_valid, out_ready);
        end
        if (rst && out_valid && out_ready) begin
            n_con++;
            tests++;
            got_v = {result, carry_out, borrow, overflow, zero};
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got %h, want no beat", got_v);
            end else begin
                exp_v = sb.pop_front();
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL scoreboard: got %h want %h", got_v, exp_v);
                end
            end
        end
        if (rst && iv && in_ready) begin
            sb.push_back(model(s, aa, bb));
            n_acc++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d beats outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        tests++;
        if ({out_valid, result, carry_out, borrow, overflow, zero} !== 37'd0) begin
            fails++;
            $display("FAIL reset_state: got out_valid=%b result=%h flags=%b%b%b%b, want all 0",
                     out_valid, result, carry_out, borrow, overflow, zero);
        end
    endtask

    task automatic test_directed();
        logic        d_s   [8];
        logic [31:0] d_a   [8];
        logic [31:0] d_b   [8];
        logic [31:0] d_r   [8];
        logic [3:0]  d_f   [8];
        d_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        d_a = '{32'd5, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd1, 32'd3};
        d_b = '{32'd3, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'd1, 32'd2, 32'd5};
        d_r = '{32'd2, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFFE};
        d_f = '{4'b1000, 4'b0100, 4'b1010, 4'b0010, 4'b1001, 4'b1001, 4'b0000, 4'b0100};
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 1'b1, d_s[n], d_a[n], d_b[n], 1'b1);
            for (int cyc = 1; cyc <= 3; cyc++) begin
                step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
                tests++;
                if (out_valid !== (cyc == 3)) begin
                    fails++;
                    $display("FAIL latency case %0d cycle %0d: got out_valid=%b want %b",
                             n, cyc, out_valid, cyc == 3);
                end
            end
            tests++;
            if ({result, carry_out, borrow, overflow, zero} !== {d_r[n], d_f[n]}) begin
                fails++;
                $display("FAIL directed case %0d: got %h c/b/o/z=%b%b%b%b want %h %b",
                         n, result, carry_out, borrow, overflow, zero, d_r[n], d_f[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        int con0;
        int stalls;
        acc0   = n_acc;
        con0   = n_con;
        stalls = 0;
        for (int k = 0; k < 60 && (n_acc - acc0 < 8 || sb.size() != 0); k++) begin
            step(1'b1, (n_acc - acc0) < 8, 1'($urandom), rnd32(), rnd32(), !(k >= 3 && k < 7));
            if (out_valid && !out_ready) stalls++;
        end
        tests++;
        if (n_acc - acc0 != 8 || n_con - con0 != 8 || sb.size() != 0 || stalls != 4) begin
            fails++;
            $display("FAIL back_to_back: got acc=%0d con=%0d left=%0d stalls=%0d want 8 8 0 4",
                     n_acc - acc0, n_con - con0, sb.size(), stalls);
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, rnd32(), rnd32(), 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'd7, 32'd9, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        tests++;
        if ({out_valid, result, carry_out, borrow, overflow, zero} !== 37'd0) begin
            fails++;
            $display("FAIL reset_midstream: got out_valid=%b result=%h flags=%b%b%b%b want all 0",
                     out_valid, result, carry_out, borrow, overflow, zero);
        end
        sb.delete();
        step(1'b1, 1'b1, 1'b1, 32'd100, 32'd58, 1'b1);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
            tests++;
            if (out_valid !== (cyc == 3)) begin
                fails++;
                $display("FAIL post_reset_beat cycle %0d: got out_valid=%b want %b",
                         cyc, out_valid, cyc == 3);
            end
            if (cyc == 3) begin
                tests++;
                if (result !== 32'd42) begin
                    fails++;
                    $display("FAIL post_reset_result: got %h want %h", result, 32'd42);
                end
            end
        end
    endtask

    task automatic test_random();
        int acc0;
        acc0 = n_acc;
        for (int k = 0; k < 60000 && n_acc - acc0 < 10000; k++) begin
            step(1'b1, ($urandom % 4) != 0, 1'($urandom), rnd32(), rnd32(), ($urandom % 4) != 0);
        end
        tests++;
        if (n_acc - acc0 < 10000) begin
            fails++;
            $display("FAIL random_budget: got %0d beats want 10000", n_acc - acc0);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        drain();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
